spi_word_bridge: RTL and testbench

- Sits between the SPI slave byte driver and the processing-unit system bus.
- Receive path: packs SPI bytes into DATA_WIDTH words and queues them in an RX FIFO. The system bus pops them with signal_oe.
- Transmit path: queues words written by the system bus (signal_wr) in a TX FIFO and unpacks them into bytes for the driver.
- Frames are delimited by cs. Sticky status is reported through attr_out.

---
 rtl/spi_word_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_word_bridge.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_word_bridge.sv
// SPI byte driver <-> system bus bridge: packs RX bytes into words, unpacks TX words into bytes.
// Optional SPI_WORD_BRIDGE_LSB_FIRST_EN selects little-endian byte order on both paths.
module spi_word_bridge_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign rdata = mem_q[rd_q];

    always_comb begin
        do_pop  = pop & ~empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push = push & (~full | do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
endmodule

module spi_word_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ATTR_WIDTH     = 4,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signal_cycle,
    input  logic                      signal_wr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [ATTR_WIDTH-1:0]     attr_in,
    input  logic                      signal_oe,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [ATTR_WIDTH-1:0]     attr_out,
    output logic                      flag_start,
    output logic                      flag_stop,
    input  logic                      spi_ready,
    input  logic [SPI_DATA_WIDTH-1:0] spi_rx_byte,
    output logic [SPI_DATA_WIDTH-1:0] spi_tx_byte,
    input  logic                      cs
);
    localparam int DW    = DATA_WIDTH;
    localparam int SW    = SPI_DATA_WIDTH;
    localparam int BYTES = DW / SW;
    localparam int CW    = $clog2(BYTES) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

`ifdef SPI_WORD_BRIDGE_LSB_FIRST_EN
    function automatic logic [SW-1:0] first_byte(input logic [DW-1:0] w);
        return w[SW-1:0];
    endfunction
    function automatic logic [DW-1:0] next_word(input logic [DW-1:0] w);
        return w >> SW;
    endfunction
    function automatic logic [DW-1:0] pack(input logic [DW-1:0] acc, input logic [SW-1:0] b);
        return (acc >> SW) | (DW'(b) << (DW - SW));
    endfunction
`else
    function automatic logic [SW-1:0] first_byte(input logic [DW-1:0] w);
        return w[DW-1 -: SW];
    endfunction
    function automatic logic [DW-1:0] next_word(input logic [DW-1:0] w);
        return w << SW;
    endfunction
    function automatic logic [DW-1:0] pack(input logic [DW-1:0] acc, input logic [SW-1:0] b);
        return (acc << SW) | DW'(b);
    endfunction
`endif

    state_t          state_q, state_d;
    logic            cs_q, cs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   acc_q, acc_d, shift_q, shift_d, data_out_q, data_out_d;
    logic [SW-1:0]   tx_byte_q, tx_byte_d;
    logic            flag_start_q, flag_start_d, flag_stop_q, flag_stop_d;
    logic            valid_q, valid_d, ovf_q, ovf_d, ferr_q, ferr_d, und_q, und_d;
    logic            ovf_set, ferr_set, und_set;
    logic            rx_push, rx_pop, rx_empty, rx_full, tx_pop, tx_empty, tx_full;
    logic [DW-1:0]   rx_head, tx_head;
    logic            cs_rise, cs_fall;
    logic            unused_in;

    assign unused_in = ^{attr_in, tx_full};
    assign cs_rise   = cs & ~cs_q;
    assign cs_fall   = ~cs & cs_q;
    assign rx_pop    = signal_oe & ~rx_empty;

    spi_word_bridge_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .wdata(acc_d), .pop(rx_pop),
        .rdata(rx_head), .empty(rx_empty), .full(rx_full)
    );

    spi_word_bridge_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(signal_wr), .wdata(data_in), .pop(tx_pop),
        .rdata(tx_head), .empty(tx_empty), .full(tx_full)
    );

    always_comb begin
        state_d      = state_q;
        cs_d         = cs;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        tx_byte_d    = tx_byte_q;
        flag_start_d = 1'b0;
        flag_stop_d  = 1'b0;
        ovf_set      = 1'b0;
        ferr_set     = 1'b0;
        und_set      = 1'b0;
        rx_push      = 1'b0;
        tx_pop       = 1'b0;

        if (cs_rise) begin
            // Frame end dominates; unsent TX bytes are simply abandoned.
            state_d     = IDLE;
            flag_stop_d = 1'b1;
            ferr_set    = (cnt_q != '0);
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d      = LOAD;
                    flag_start_d = 1'b1;
                end
                LOAD: begin
                    tx_pop    = ~tx_empty;
                    und_set   = tx_empty;
                    shift_d   = tx_empty ? '0 : tx_head;
                    tx_byte_d = first_byte(shift_d);
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = XFER;
                end
                XFER: if (spi_ready) begin
                    acc_d = pack(acc_q, spi_rx_byte);
                    if (cnt_q == CW'(BYTES - 1)) begin
                        rx_push = 1'b1;
                        ovf_set = rx_full & ~rx_pop;
                        cnt_d   = '0;
                        tx_pop  = ~tx_empty;
                        und_set = tx_empty;
                        shift_d = tx_empty ? '0 : tx_head;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = next_word(shift_q);
                    end
                    tx_byte_d = first_byte(shift_d);
                end
                default: state_d = IDLE;
            endcase
        end

        data_out_d = data_out_q;
        valid_d    = valid_q;
        if (signal_oe) begin
            data_out_d = rx_empty ? '0 : rx_head;
            valid_d    = ~rx_empty;
        end

        ovf_d  = ovf_set  | (ovf_q  & ~signal_cycle);
        ferr_d = ferr_set | (ferr_q & ~signal_cycle);
        und_d  = und_set  | (und_q  & ~signal_cycle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cs_q         <= 1'b1;
            cnt_q        <= '0;
            acc_q        <= '0;
            shift_q      <= '0;
            tx_byte_q    <= '0;
            flag_start_q <= 1'b0;
            flag_stop_q  <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            ferr_q       <= 1'b0;
            und_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_q         <= cs_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            tx_byte_q    <= tx_byte_d;
            flag_start_q <= flag_start_d;
            flag_stop_q  <= flag_stop_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            ferr_q       <= ferr_d;
            und_q        <= und_d;
        end
    end

    always_comb begin
        attr_out      = '0;
        attr_out[3:0] = {und_q, ferr_q, ovf_q, valid_q};
    end

    assign data_out    = data_out_q;
    assign flag_start  = flag_start_q;
    assign flag_stop   = flag_stop_q;
    assign spi_tx_byte = tx_byte_q;
endmodule

// File: tb/tb_spi_word_bridge.sv
// Directed bench for spi_word_bridge (default big-endian build, 32-bit words, FIFO depth 4).
module tb_spi_word_bridge;
    logic        clk = 1'b0;
    logic        rst, signal_cycle, signal_wr, signal_oe, flag_start, flag_stop, spi_ready, cs;
    logic [31:0] data_in, data_out;
    logic [3:0]  attr_in, attr_out;
    logic [7:0]  spi_rx_byte, spi_tx_byte;
    int          n_chk = 0;
    int          n_fail = 0;

    spi_word_bridge dut (
        .clk(clk), .rst(rst), .signal_cycle(signal_cycle), .signal_wr(signal_wr),
        .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe), .data_out(data_out),
        .attr_out(attr_out), .flag_start(flag_start), .flag_stop(flag_stop),
        .spi_ready(spi_ready), .spi_rx_byte(spi_rx_byte), .spi_tx_byte(spi_tx_byte), .cs(cs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_ready = 1'b1; spi_rx_byte = b;
        tick();
        spi_ready = 1'b0;
    endtask

    task automatic pop();
        signal_oe = 1'b1;
        tick();
        signal_oe = 1'b0;
    endtask

    task automatic cycle_pulse();
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
    endtask

    task automatic frame_begin();
        cs = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_end();
        cs = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] exp_tx [4];
        exp_tx[0] = 8'hB2; exp_tx[1] = 8'hC3; exp_tx[2] = 8'hD4; exp_tx[3] = 8'h00;
        rst = 1'b1; signal_cycle = 0; signal_wr = 0; signal_oe = 0; spi_ready = 0;
        cs = 1'b1; data_in = '0; attr_in = 4'hF; spi_rx_byte = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_data_out", data_out, 0);
        chk("rst_attr", attr_out, 0);
        chk("rst_tx_byte", spi_tx_byte, 0);
        chk("rst_flags", {flag_start, flag_stop}, 0);

        // basic word exchange
        signal_wr = 1'b1; data_in = 32'hA1B2C3D4;
        tick();
        signal_wr = 1'b0;
        cs = 1'b0;
        tick();
        chk("t1_flag_start", flag_start, 1);
        tick();
        chk("t1_flag_start_off", flag_start, 0);
        chk("t1_tx0", spi_tx_byte, 8'hA1);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h11 * (i + 1));
            chk($sformatf("t1_tx%0d", i + 1), spi_tx_byte, exp_tx[i]);
        end
        frame_end();
        chk("t1_flag_stop", flag_stop, 1);
        tick();
        chk("t1_flag_stop_off", flag_stop, 0);
        cycle_pulse();
        pop();
        chk("t1_data", data_out, 32'h11223344);
        chk("t1_attr", attr_out, 4'b0001);

        // 8-byte frame, TX empty
        cycle_pulse();
        frame_begin();
        chk("t2_tx_load", spi_tx_byte, 0);
        for (int i = 1; i <= 8; i++) begin
            spi_byte(8'(i));
            chk("t2_tx_zero", spi_tx_byte, 0);
        end
        frame_end();
        chk("t2_und", attr_out[3], 1);
        pop();
        chk("t2_w0", data_out, 32'h01020304);
        chk("t2_attr0", attr_out, 4'b1001);
        pop();
        chk("t2_w1", data_out, 32'h05060708);
        pop();
        chk("t2_empty_data", data_out, 0);
        chk("t2_empty_attr", attr_out, 4'b1000);

        // 6-byte frame -> partial word discarded
        cycle_pulse();
        frame_begin();
        for (int i = 0; i < 6; i++) spi_byte(8'h10 + 8'(i));
        chk("t3_ferr_pre", attr_out[2], 0);
        frame_end();
        chk("t3_ferr", attr_out[2], 1);
        pop();
        chk("t3_w0", data_out, 32'h10111213);
        pop();
        chk("t3_partial_hidden", {attr_out[0], data_out}, 0);

        // RX overflow, 5 words into depth 4
        cycle_pulse();
        frame_begin();
        for (int k = 1; k <= 5; k++)
            for (int j = 0; j < 4; j++) spi_byte(8'(k));
        frame_end();
        chk("t4_ovf", attr_out[1], 1);
        for (int k = 1; k <= 4; k++) begin
            pop();
            chk($sformatf("t4_w%0d", k), data_out, {4{8'(k)}});
        end
        pop();
        chk("t4_fifth", {attr_out[0], data_out}, 0);

        // overflow coincident with signal_cycle
        cycle_pulse();
        frame_begin();
        for (int i = 0; i < 16; i++) spi_byte(8'h30 + 8'(i / 4));
        chk("t5_no_ovf_yet", attr_out[1], 0);
        for (int i = 0; i < 3; i++) spi_byte(8'h40);
        signal_cycle = 1'b1;
        spi_byte(8'h40);
        signal_cycle = 1'b0;
        chk("t5_set_wins", attr_out[1], 1);
        cycle_pulse();
        chk("t5_cleared", attr_out[1], 0);
        frame_end();

        // reset mid-frame flushes everything
        pop();
        chk("t6_pre_pop", data_out, 32'h30303030);
        signal_wr = 1'b1; data_in = 32'hCAFEBABE;
        tick();
        signal_wr = 1'b0;
        frame_begin();
        spi_byte(8'h55);
        spi_byte(8'h66);
        chk("t6_tx_mid", spi_tx_byte, 8'hBA);
        rst = 1'b1; cs = 1'b1;
        tick();
        chk("t6_rst_out", {data_out, attr_out, spi_tx_byte, flag_start, flag_stop}, 0);
        rst = 1'b0;
        tick();
        chk("t6_no_stop", flag_stop, 0);
        pop();
        chk("t6_flushed", {attr_out[0], data_out}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
